// File: rtl/sobel_window.sv
// sobel_window: streaming 3x3 neighbourhood generator feeding the Sobel stage.
// Pixels arrive in raster order; two line buffers supply the two previous
// lines and a 3x3 register window is packed into a 9-byte output word.
// Optional feature macro: SOBEL_WINDOW_ZERO_BORDER_EN -- emit one word per
// pixel, with zero words for the top two rows and left two columns.
module sobel_window #(
   parameter int WIDTH      = 720,
   parameter int HEIGHT     = 540,
   parameter int DWIDTH_IN  = 8,
   parameter int DWIDTH_OUT = 72
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DWIDTH_IN-1:0]  in_din,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   output logic [DWIDTH_OUT-1:0] out_dout,
   input  logic                  out_full,
   output logic                  out_wr_en
);

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   typedef logic [DWIDTH_IN-1:0] pix_t;

   // Line buffers are circular memories addressed by the column counter:
   // each slot is rewritten exactly once per line, giving a WIDTH-read delay.
   pix_t lb1_mem [WIDTH];
   pix_t lb0_mem [WIDTH];
   pix_t lb1_out;
   pix_t lb0_out;

   pix_t                  win_q [3][3];
   pix_t                  win_d [3][3];
   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic                  out_valid_q, out_valid_d;
   logic [DWIDTH_OUT-1:0] out_dout_q, out_dout_d;
   logic [DWIDTH_OUT-1:0] win_packed;
   logic                  rd;
   logic                  wr;
   logic                  qualify;
   logic                  load;

   assign lb1_out   = lb1_mem[col_q];
   assign lb0_out   = lb0_mem[col_q];
   assign in_rd_en  = rd;
   assign out_wr_en = wr;
   assign out_dout  = out_dout_q;

   // Handshakes, window shift, position counters and output word selection.
   always_comb begin
      rd          = !in_empty && (!out_valid_q || !out_full);
      wr          = out_valid_q && !out_full;
      qualify     = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      win_d       = win_q;
      col_d       = col_q;
      row_d       = row_q;
      win_packed  = '0;
      out_valid_d = out_valid_q;
      out_dout_d  = out_dout_q;
      load        = 1'b0;

      if (rd) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][2] = win_q[r][1];
            win_d[r][1] = win_q[r][0];
         end
         win_d[2][0] = in_din;
         win_d[1][0] = lb1_out;
         win_d[0][0] = lb0_out;

         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            win_packed[(3*r + c)*DWIDTH_IN +: DWIDTH_IN] = win_d[r][c];
         end
      end

`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
      load = rd;
      if (load) out_dout_d = qualify ? win_packed : '0;
`else
      load = rd && qualify;
      if (load) out_dout_d = win_packed;
`endif

      // A new window wins over a write that drains the previous one.
      if (load)    out_valid_d = 1'b1;
      else if (wr) out_valid_d = 1'b0;
   end

   // Control and window state with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '{default: '0};
         out_valid_q <= 1'b0;
         out_dout_q  <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_dout_q  <= out_dout_d;
      end
   end

   // Line buffer storage is never reset; rows 0..1 of each frame refill it.
   always_ff @(posedge clock) begin
      if (rd) begin
         lb1_mem[col_q] <= in_din;
         lb0_mem[col_q] <= lb1_out;
      end
   end

endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window on a 4x4 image: the testbench acts as both FIFOs and
// predicts every window from a stored copy of the current frame.
module tb_sobel_window;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DI = 8;
   localparam int DO = 72;
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
   localparam int EXPW = W * H;
`else
   localparam int EXPW = (W - 2) * (H - 2);
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [DI-1:0] in_din;
   logic          in_empty;
   logic          in_rd_en;
   logic [DO-1:0] out_dout;
   logic          out_full;
   logic          out_wr_en;

   sobel_window #(.WIDTH(W), .HEIGHT(H), .DWIDTH_IN(DI), .DWIDTH_OUT(DO)) dut (
      .clock    (clock),
      .reset    (reset),
      .in_din   (in_din),
      .in_empty (in_empty),
      .in_rd_en (in_rd_en),
      .out_dout (out_dout),
      .out_full (out_full),
      .out_wr_en(out_wr_en)
   );

   always #5 clock = ~clock;

   int            checks   = 0;
   int            failures = 0;
   logic [DI-1:0] src_q[$];
   logic [DO-1:0] exp_q[$];
   logic [DO-1:0] wr_log[$];
   logic [DO-1:0] basic[$];
   int            mrow = 0;
   int            mcol = 0;
   logic [DI-1:0] img[H][W];

   task automatic check(input string tag, input logic [DO-1:0] obs, input logic [DO-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Window for a read at (r,c): byte 3*rr+cc is row r-2+rr, column c-cc.
   function automatic logic [DO-1:0] window_at(input int r, input int c);
      logic [DO-1:0] w;
      w = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[(3*rr + cc)*DI +: DI] = img[r-2+rr][c-cc];
      return w;
   endfunction

   task automatic model_read(input logic [DI-1:0] p);
      img[mrow][mcol] = p;
      if (mrow >= 2 && mcol >= 2) exp_q.push_back(window_at(mrow, mcol));
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
      else exp_q.push_back('0);
`endif
      if (mcol == W - 1) begin
         mcol = 0;
         mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
         mcol++;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      mrow = 0;
      mcol = 0;
   endtask

   task automatic load_ramp(input int n);
      for (int i = 0; i < n; i++) src_q.push_back(DI'(i % (W*H)));
   endtask

   // empty_mode: 0 none, 1 toggle, 2 random. full_mode: 0 none,
   // 1 five-cycle hold at first write, 2 random, 3 always full (bounded run).
   task automatic run(input int empty_mode, input int full_mode);
      int cyc     = 0;
      bit bp_done = 0;
      int bp_left = 0;
      bit toggle  = 0;
      while (src_q.size() > 0 || (exp_q.size() > 0 && full_mode != 3)) begin
         if (full_mode == 3 && cyc >= 40) break;
         if (cyc >= 3000) begin
            checks++;
            failures++;
            $error("FAIL timeout cycles=%0d limit=3000", cyc);
            break;
         end
         @(negedge clock);
         case (empty_mode)
            1:       begin in_empty = (src_q.size() == 0) || toggle; toggle = !toggle; end
            2:       in_empty = (src_q.size() == 0) || ($urandom_range(0, 2) == 0);
            default: in_empty = (src_q.size() == 0);
         endcase
         in_din = (src_q.size() > 0) ? src_q[0] : DI'($urandom);
         case (full_mode)
            1: begin
               if (!bp_done && exp_q.size() > 0) begin bp_left = 5; bp_done = 1; end
               out_full = (bp_left > 0);
               if (bp_left > 0) bp_left--;
            end
            2:       out_full = ($urandom_range(0, 2) == 0);
            3:       out_full = 1'b1;
            default: out_full = 1'b0;
         endcase
         #1;
         check("in_rd_en", DO'(in_rd_en), DO'(!in_empty && (exp_q.size() == 0 || !out_full)));
         check("out_wr_en", DO'(out_wr_en), DO'(exp_q.size() > 0 && !out_full));
         if (exp_q.size() > 0) check("out_dout", out_dout, exp_q[0]);
         if (out_wr_en) begin
            wr_log.push_back(out_dout);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_rd_en && src_q.size() > 0) model_read(src_q.pop_front());
         cyc++;
      end
      @(negedge clock);
      in_empty = 1'b1;
      out_full = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset    = 1'b1;
      in_empty = 1'b1;
      out_full = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         check("wr_en_in_reset", DO'(out_wr_en), '0);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic compare_basic(input string tag, input int offset);
      for (int i = 0; i < EXPW; i++)
         if (offset + i < wr_log.size()) check(tag, wr_log[offset + i], basic[i]);
   endtask

   initial begin
      reset    = 1'b1;
      in_empty = 1'b1;
      out_full = 1'b0;
      in_din   = '0;
      do_reset(2);
      #1;
      check("reset_dout", out_dout, '0);
      check("reset_wr_en", DO'(out_wr_en), '0);
      check("reset_rd_en", DO'(in_rd_en), '0);

      // Basic frame
      wr_log.delete();
      load_ramp(16);
      run(0, 0);
      check("basic_count", DO'(wr_log.size()), DO'(EXPW));
      if (wr_log.size() == EXPW) begin
`ifdef SOBEL_WINDOW_ZERO_BORDER_EN
         for (int i = 0; i < 10; i++) check("zb_border", wr_log[i], '0);
         check("zb_pix12", wr_log[12], '0);
         check("zb_pix13", wr_log[13], '0);
         check("zb_pix10", wr_log[10], 72'h08_09_0A_04_05_06_00_01_02);
`else
         check("basic_first", wr_log[0], 72'h08_09_0A_04_05_06_00_01_02);
         check("basic_last", wr_log[3], 72'h0D_0E_0F_09_0A_0B_05_06_07);
`endif
      end
      basic = wr_log;

      // Backpressure at first write
      wr_log.delete();
      load_ramp(16);
      run(0, 1);
      check("bp_count", DO'(wr_log.size()), DO'(EXPW));
      compare_basic("bp_window", 0);

      // Bursty input
      wr_log.delete();
      load_ramp(16);
      run(1, 0);
      check("burst_count", DO'(wr_log.size()), DO'(EXPW));
      compare_basic("burst_window", 0);

      // Back-to-back frames
      wr_log.delete();
      load_ramp(32);
      run(0, 0);
      check("b2b_count", DO'(wr_log.size()), DO'(2 * EXPW));
      compare_basic("b2b_first", 0);
      compare_basic("b2b_second", EXPW);

      // Reset mid-frame after pixel 9
      load_ramp(10);
      run(0, 0);
      do_reset(2);
      wr_log.delete();
      load_ramp(16);
      run(0, 0);
      check("midrst_count", DO'(wr_log.size()), DO'(EXPW));
      compare_basic("midrst_window", 0);

      // Reset with a window stuck behind a full downstream
      load_ramp(12);
      run(0, 3);
      src_q.delete();
      do_reset(1);
      wr_log.delete();
      load_ramp(16);
      run(0, 0);
      check("discard_count", DO'(wr_log.size()), DO'(EXPW));
      compare_basic("discard_window", 0);

      // Random pixels with random stalls on both sides
      wr_log.delete();
      for (int i = 0; i < 3 * W * H; i++) src_q.push_back(DI'($urandom));
      run(2, 2);
      check("rand_count", DO'(wr_log.size()), DO'(3 * EXPW));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sobel_window.md
# sobel_window

Streaming 3x3 window generator that sits directly upstream of the Sobel operator. It consumes one 8-bit grayscale pixel per cycle from an input FIFO in raster order. It keeps the two previous image lines in line buffers and writes the 72-bit 3x3 neighbourhood word that the Sobel stage consumes into an output FIFO. It uses FIFO-style handshakes on both sides and sustains one pixel per cycle when neither side stalls.

## Interface
- WIDTH, 720: image width in pixels (>= 3)
- HEIGHT, 540: image height in lines (>= 3)
- DWIDTH_IN, 8: pixel width
- DWIDTH_OUT, 72: window width (9*DWIDTH_IN)

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_din  in  DWIDTH_IN  pixel from upstream FIFO
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO this cycle
- out_dout  out  DWIDTH_OUT  window word to downstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push out_dout this cycle

## Operation
- Pixel read: a pixel is consumed on any cycle where in_rd_en=1. in_rd_en = !in_empty && (!out_valid || !out_full). The combinational term is permitted.
- Position counters col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the pixel being read.
  - col increments on each read.
  - At col=WIDTH-1, col wraps to 0 and row increments.
  - At row=HEIGHT-1 with col=WIDTH-1, both wrap to 0 for the next frame. There is no inter-frame gap.
- Line buffers:
  - lb1 delays pixels by exactly WIDTH reads.
  - lb0 delays lb1's output by a further WIDTH reads.
  - Both advance only on reads.
  - Contents are not reset.
- Window registers w[r][c], r=0 top (oldest line) to r=2 bottom (current line), c=0 newest column.
  - On each read: w[r][2]<=w[r][1], w[r][1]<=w[r][0], w[2][0]<=in_din, w[1][0]<=lb1 out, w[0][0]<=lb0 out.
- Packing: out_dout[k*8 +: 8] = w[r][c] with k = 3r + c. Byte 0 is the top-right pixel (newest column, oldest line). Byte 8 is the bottom-left pixel.
- Window qualification: a read at (row>=2, col>=2) sets out_valid on the next edge and loads out_dout. The resulting window's centre pixel is at (row-1, col-1).
- Output frame size: (WIDTH-2)*(HEIGHT-2) windows per frame.
- Write: out_wr_en = out_valid && !out_full.
- out_valid after each edge:
  - Set to 1 if a qualifying read occurs.
  - Otherwise cleared to 0 if a write occurs.
  - Otherwise holds.
- A write and a new qualifying read in the same cycle: the new window replaces the old one and out_valid stays 1.
- Non-qualifying reads leave out_dout unchanged. This rule applies only when out_valid=0 or a write occurs in the same cycle, which the in_rd_en rule guarantees.

## Timing
- Reset values:
  - out_dout = 0, out_wr_en = 0 (out_valid = 0).
  - in_rd_en follows its formula with out_valid = 0.
  - col = row = 0. Window registers = 0.
- Latency: the pixel read at edge t appears in out_dout with out_wr_en=1 in the cycle after edge t, if out_full=0.
- Throughput: 1 window per cycle under no stall.
- Backpressure:
  - While out_valid=1 and out_full=1, in_rd_en=0 and out_dout holds.
  - No pixel is dropped or duplicated.
- Upstream empty: counters and buffers freeze. A pending window is still written when out_full=0.
- Reset mid-frame: the next pixel read is treated as (0,0) of a new frame. A pending window is discarded.
- No arithmetic on data; counters are sized ceil(log2(WIDTH)) and ceil(log2(HEIGHT)).

## Configuration
- SOBEL_WINDOW_ZERO_BORDER_EN
- Undefined: behaviour as above, (WIDTH-2)*(HEIGHT-2) writes per frame.
- Defined:
  - Every read sets out_valid, giving WIDTH*HEIGHT writes per frame.
  - Reads at row<2 or col<2 load out_dout = 0 instead of the window.
  - Downstream therefore receives a full-size frame with zero gradient on the top two rows and left two columns.
  - The rest of the frame is offset by (1,1) relative to the image.

## Test plan
- Basic frame: WIDTH=4, HEIGHT=4, pixels 0..15, out_full=0.
  - Exactly 4 writes.
  - First write occurs the cycle after reading pixel 10, with bytes k0..k8 = 2,1,0,6,5,4,10,9,8.
  - Last write (after reading pixel 15) has bytes 7,6,5,11,10,9,15,14,13.
- Backpressure: hold out_full=1 for 5 cycles starting at the first write.
  - in_rd_en=0 and out_dout is stable throughout.
  - All 4 windows are still delivered in order, none duplicated.
- Bursty input: toggle in_empty every other cycle.
  - Output windows are identical to the basic-frame test.
- Back-to-back frames: 32 pixels (two frames, values 0..15 repeated).
  - 8 writes, second group identical to the first.
- Reset mid-frame: assert reset after reading pixel 9, then stream a fresh frame of 0..15.
  - out_wr_en=0 during reset.
  - Exactly 4 writes whose values match the basic-frame test.
- With SOBEL_WINDOW_ZERO_BORDER_EN on the basic frame:
  - 16 writes.
  - The first 10 writes and the writes after reading pixels 12 and 13 are zero.
  - The write after pixel 10 is 2,1,0,6,5,4,10,9,8.
